// File: rtl/debug_frame_sender_if.sv
// rtl/debug_frame_sender_if.sv - byte handshake between the debug frame sender and tx_uart
interface debug_frame_sender_if #(
    parameter int N_BITS = 8
);
    logic [N_BITS-1:0] tx_data;
    logic              tx_start;
    logic              tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_done
    );
endinterface

// File: rtl/debug_frame_sender.sv
// rtl/debug_frame_sender.sv - serialises PC, cycle count, registers and memory into UART bytes
// Optional trailing XOR checksum byte: DEBUG_FRAME_CHECKSUM_EN
module debug_frame_sender #(
    parameter int NB_DATA     = 32,
    parameter int N_BITS      = 8,
    parameter int N_BYTES     = 4,
    parameter int N_REGISTER  = 32,
    parameter int NB_REG      = 5,
    parameter int N_MEM_WORDS = 16,
    parameter int NB_MEM_ADDR = 7,
    parameter int NB_IDX      = 6
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [NB_DATA-1:0]     pc_i,
    input  logic [NB_DATA-1:0]     cycle_count_i,
    output logic [NB_REG-1:0]      reg_addr_o,
    input  logic [NB_DATA-1:0]     reg_data_i,
    output logic [NB_MEM_ADDR-1:0] mem_addr_o,
    input  logic [NB_DATA-1:0]     mem_data_i,
    debug_frame_sender_if.master   tx_if,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int NB_BCNT = $clog2(N_BYTES) + 1;
    localparam logic [NB_IDX-1:0]  IDX_CNT   = NB_IDX'(1);
    localparam logic [NB_IDX-1:0]  IDX_REG0  = NB_IDX'(2);
    localparam logic [NB_IDX-1:0]  IDX_MEM0  = NB_IDX'(2 + N_REGISTER);
    localparam logic [NB_IDX-1:0]  IDX_LAST  = NB_IDX'(1 + N_REGISTER + N_MEM_WORDS);
    localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(N_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        WAIT,
`ifdef DEBUG_FRAME_CHECKSUM_EN
        CHKSUM,
`endif
        DONE
    } state_t;

`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam state_t FRAME_END = CHKSUM;
`else
    localparam state_t FRAME_END = DONE;
`endif

    state_t               state;
    state_t               state_next;
    logic [NB_IDX-1:0]    idx;
    logic [NB_IDX-1:0]    idx_inc;
    logic [NB_BCNT-1:0]   bcnt;
    logic [NB_DATA-1:0]   shift_reg;
    logic [NB_DATA-1:0]   pc_q;
    logic [NB_DATA-1:0]   cnt_q;
    logic [NB_DATA-1:0]   load_word;
    logic [N_BITS-1:0]    tx_data_q;
    logic [NB_REG-1:0]    reg_addr_q;
    logic [NB_MEM_ADDR-1:0] mem_addr_q;
    logic                 tx_start;
    logic                 busy;
    logic                 done;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    logic [N_BITS-1:0]    chk_q;
    logic                 chk_phase;
`endif

    assign idx_inc        = idx + NB_IDX'(1);
    assign tx_if.tx_data  = tx_data_q;
    assign tx_if.tx_start = tx_start;
    assign reg_addr_o     = reg_addr_q;
    assign mem_addr_o     = mem_addr_q;
    assign busy_o         = busy;
    assign done_o         = done;

    always_comb begin
        if (idx == '0) begin
            load_word = pc_q;
        end else if (idx == IDX_CNT) begin
            load_word = cnt_q;
        end else if (idx < IDX_MEM0) begin
            load_word = reg_data_i;
        end else begin
            load_word = mem_data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_i) begin
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD:  state_next = SEND;
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_if.tx_done) begin
                    if (bcnt != BCNT_LAST) begin
                        state_next = SEND;
                    end else if (idx != IDX_LAST) begin
                        state_next = FETCH;
                    end else begin
                        state_next = FRAME_END;
                    end
`ifdef DEBUG_FRAME_CHECKSUM_EN
                    if (chk_phase) begin
                        state_next = DONE;
                    end
`endif
                end
            end
`ifdef DEBUG_FRAME_CHECKSUM_EN
            CHKSUM: state_next = SEND;
`endif
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read addresses are set on the way into FETCH so the synchronous read data is ready in LOAD.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            idx        <= '0;
            bcnt       <= '0;
            shift_reg  <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            chk_q      <= '0;
            chk_phase  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        pc_q  <= pc_i;
                        cnt_q <= cycle_count_i;
                        idx   <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
                        chk_q     <= '0;
                        chk_phase <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    shift_reg <= load_word;
                    bcnt      <= '0;
                    tx_data_q <= load_word[N_BITS-1:0];
`ifdef DEBUG_FRAME_CHECKSUM_EN
                    chk_q     <= chk_q ^ load_word[N_BITS-1:0];
`endif
                end
                WAIT: begin
                    if (tx_if.tx_done) begin
                        shift_reg <= shift_reg >> N_BITS;
                        bcnt      <= bcnt + NB_BCNT'(1);
                        if (state_next == SEND) begin
                            tx_data_q <= shift_reg[2*N_BITS-1:N_BITS];
`ifdef DEBUG_FRAME_CHECKSUM_EN
                            chk_q     <= chk_q ^ shift_reg[2*N_BITS-1:N_BITS];
`endif
                        end else if (state_next == FETCH) begin
                            idx <= idx_inc;
                            if (idx_inc >= IDX_REG0 && idx_inc < IDX_MEM0) begin
                                reg_addr_q <= NB_REG'(idx_inc - IDX_REG0);
                            end else if (idx_inc >= IDX_MEM0) begin
                                mem_addr_q <= NB_MEM_ADDR'(idx_inc - IDX_MEM0);
                            end
                        end
                    end
                end
`ifdef DEBUG_FRAME_CHECKSUM_EN
                CHKSUM: begin
                    tx_data_q <= chk_q;
                    chk_phase <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
